// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter for instruction fetch and data access.
// Data has strict priority over fetch. Every access holds the memory port for WAIT_CYCLES+1 cycles.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned AW          = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_cancel_i,
  output logic          if_ready_o,
  output logic [31:0]   if_rdata_o,
  output logic          if_stall_o,
  input  logic          d_rd_i,
  input  logic          d_wr_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [31:0]   d_wdata_i,
  output logic          d_ready_o,
  output logic [31:0]   d_rdata_o,
  output logic          d_stall_o,
  output logic          m_en_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [31:0]   m_wdata_o,
  input  logic [31:0]   m_rdata_i
);

  // state  | meaning
  // IDLE   | memory port idle; grant data first, then fetch
  // D_ACC  | data access in flight
  // I_ACC  | instruction fetch in flight
  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [3:0]      cnt_d;
  logic            m_en_q;
  logic            m_we_q;
  logic [AW-1:0]   m_addr_q;
  logic [31:0]     m_wdata_q;
  logic            if_ready_q;
  logic            d_ready_q;
  logic [31:0]     if_rdata_q;
  logic [31:0]     d_rdata_q;

  assign cnt_d = cnt_q - 4'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= 32'd0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (d_rd_i || d_wr_i) begin
            state_q   <= D_ACC;
            cnt_q     <= WAIT_LD;
            m_en_q    <= 1'b1;
            m_we_q    <= d_wr_i;
            m_addr_q  <= d_addr_i;
            m_wdata_q <= d_wdata_i;
            d_ready_q <= ZERO_WAIT;
          end else if (if_req_i && !if_cancel_i) begin
            state_q    <= I_ACC;
            cnt_q      <= WAIT_LD;
            m_en_q     <= 1'b1;
            m_we_q     <= 1'b0;
            m_addr_q   <= if_addr_i;
            if_ready_q <= ZERO_WAIT;
          end
        end
        D_ACC: begin
          if (cnt_q == 4'd0) begin
            state_q   <= IDLE;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            d_ready_q <= 1'b0;
            if (!m_we_q) d_rdata_q <= m_rdata_i;
          end else begin
            cnt_q     <= cnt_d;
            d_ready_q <= (cnt_q == 4'd1);
          end
        end
        I_ACC: begin
          // A cancel landing on the completion cycle also suppresses the ready pulse (see if_ready_o).
          if (if_cancel_i || cnt_q == 4'd0) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            m_en_q     <= 1'b0;
            if_ready_q <= 1'b0;
            if (!if_cancel_i) if_rdata_q <= m_rdata_i;
          end else begin
            cnt_q      <= cnt_d;
            if_ready_q <= (cnt_q == 4'd1);
          end
        end
        default: begin
          state_q <= IDLE;
          m_en_q  <= 1'b0;
          m_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_ready_o = if_ready_q & ~if_cancel_i;
  assign d_ready_o  = d_ready_q;
  assign if_rdata_o = if_ready_o ? m_rdata_i : if_rdata_q;
  assign d_rdata_o  = d_ready_q  ? m_rdata_i : d_rdata_q;
  assign d_stall_o  = (d_rd_i | d_wr_i) & ~d_ready_o;
  assign if_stall_o = d_stall_o | (if_req_i & ~if_ready_o);
  assign m_en_o     = m_en_q;
  assign m_we_o     = m_we_q;
  assign m_addr_o   = m_addr_q;
  assign m_wdata_o  = m_wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, meaning wait states the shared memory needs before read data is valid (range 0..15).
REQ-002 Parameter AW, default 32, meaning byte address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  instruction-fetch read request; held until if_ready.
REQ-006 if_addr  in  AW  fetch address (PC register output).
REQ-007 if_cancel  in  1  branch taken; abort the pending or in-flight fetch.
REQ-008 if_ready  out  1  one-cycle pulse; fetch complete, if_rdata valid.
REQ-009 if_rdata  out  32  fetched instruction word.
REQ-010 if_stall  out  1  freeze request to the fetch stage.
REQ-011 d_rd  in  1  data read request from MEM stage; held until d_ready.
REQ-012 d_wr  in  1  data write request; held until d_ready.
REQ-013 d_addr  in  AW  data address.
REQ-014 d_wdata  in  32  write data.
REQ-015 d_ready  out  1  one-cycle pulse; data access complete.
REQ-016 d_rdata  out  32  read data, valid with d_ready on reads.
REQ-017 d_stall  out  1  whole-pipeline freeze request.
REQ-018 m_en  out  1  shared memory enable.
REQ-019 m_we  out  1  shared memory write enable.
REQ-020 m_addr  out  AW  shared memory address.
REQ-021 m_wdata  out  32  shared memory write data.
REQ-022 m_rdata  in  32  shared memory read data, valid WAIT_CYCLES cycles after m_en first asserts with stable address.

Function
REQ-023 FSM states: IDLE, D_ACC, I_ACC; state register and wait counter of 4 bits.
REQ-024 In IDLE with d_rd or d_wr high, the block SHALL enter D_ACC next cycle, latching d_addr, d_wdata and the write flag; data has strict priority over fetch.
REQ-025 In IDLE with only if_req high and if_cancel low, the block SHALL enter I_ACC next cycle, latching if_addr.
REQ-026 d_rd and d_wr both high SHALL be treated as a write.
REQ-027 In D_ACC/I_ACC, m_en=1, m_addr/m_wdata/m_we SHALL be driven from latched values and held stable; counter loads WAIT_CYCLES on entry and decrements each cycle.
REQ-028 Access completes in the cycle the counter is 0: the matching ready SHALL pulse for exactly that cycle, rdata SHALL equal m_rdata in that cycle and be held registered until the next completion, state returns to IDLE.
REQ-029 Latency from request seen in IDLE to ready SHALL be WAIT_CYCLES+2 cycles; back-to-back requests incur one IDLE cycle between accesses.
REQ-030 d_stall = (d_rd|d_wr) & ~d_ready; if_stall = d_stall | (if_req & ~if_ready); both combinational.
REQ-031 if_cancel high in I_ACC SHALL return the FSM to IDLE next cycle with no if_ready pulse; if_cancel in IDLE SHALL block fetch start that cycle.
REQ-032 if_cancel SHALL have no effect on D_ACC.
REQ-033 A data request arriving during I_ACC SHALL wait for fetch completion (no preemption), then be granted in the following IDLE cycle even if if_req is also high.
REQ-034 In IDLE m_en=0, m_we=0; m_we SHALL never be high outside D_ACC with write flag set.
REQ-035 Requests deasserted mid-access (protocol violation) SHALL not corrupt state: access completes, ready pulses, FSM returns to IDLE.

Reset
REQ-036 rst high SHALL force IDLE, counter 0, if_ready=0, d_ready=0, m_en=0, m_we=0, if_rdata=0, d_rdata=0 next edge, including mid-access; an in-flight write SHALL be dropped.
REQ-037 m_addr and m_wdata SHALL reset to 0.

Verification
REQ-038 WAIT_CYCLES=2, if_req with if_addr=0x10 from IDLE -> m_en high 3 cycles, if_ready pulses cycle 4 with if_rdata=m_rdata, if_stall high cycles 1-3.
REQ-039 d_rd and if_req asserted same cycle -> D_ACC first, d_ready at cycle 4, I_ACC starts cycle 6, if_ready at cycle 8; if_stall high throughout until if_ready.
REQ-040 d_wr addr=0x40 data=0xDEADBEEF -> m_we=1 for 3 cycles with stable addr/data, d_ready pulse, memory reads back 0xDEADBEEF.
REQ-041 if_cancel in second cycle of I_ACC -> no if_ready, IDLE next cycle, new fetch accepted next cycle.
REQ-042 rst during D_ACC write -> all outputs zero next cycle, m_we low, no d_ready.
REQ-043 WAIT_CYCLES=0 -> ready pulses on second cycle after request, one m_en cycle per access.
